// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop.
// Parity is compiled in with `define UART_TX_PARITY_EN (adds parity_odd input).
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx_ready,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 tx_q, tx_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          state_d = S_START;
          tx_d    = 1'b0;
          en_d    = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ parity_odd;
`endif
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          cnt_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (cnt_q == LAST_DATA) begin
            cnt_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= 3'd0;
      tx_q    <= 1'b1;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign baud_en  = en_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame table plus reset, back-to-back and stall cases.
// Includes a small uart_baud_gen model that re-syncs on the en rising edge.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       parity_odd;
  logic       tx_ready;
  logic       baud_tick;
  logic       baud_en;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int div;
  int cnt;
  int n_pass;
  int n_total;

  uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx_ready  (tx_ready),
    .baud_tick (baud_tick),
    .baud_en   (baud_en),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // Divider model: first tick D cycles after en rises, then every D cycles.
  always @(posedge clk) begin
    if (!baud_en) begin
      cnt       <= 0;
      baud_tick <= 1'b0;
    end else if (div == 0) begin
      baud_tick <= 1'b0;
    end else if (cnt >= div - 1) begin
      cnt       <= 0;
      baud_tick <= 1'b1;
    end else begin
      cnt       <= cnt + 1;
      baud_tick <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       podd;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  function automatic logic [4:0] obs();
    return {tx, tx_busy, baud_en, tx_done, tx_ready};
  endfunction

  function automatic logic exp_tx(input vec_t v, input int k);
    int idx;
    if (k <= v.div) return 1'b0;
    idx = 1 + (k - v.div - 1) / v.div;
    if (idx <= 8) return v.frame[idx];
    if (PAR == 1 && idx == 9) return v.par;
    return 1'b1;
  endfunction

  function automatic int frame_len(input vec_t v);
    return v.div + 1 + (NBITS - 1) * v.div;
  endfunction

  task automatic chk(input string name, input logic [4:0] act,
                     input logic [4:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got {tx,busy,en,done,rdy}=%b want %b t=%0t",
               name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic send(input vec_t v, input logic keep);
    div        = v.div;
    tx_data    = v.data;
    parity_odd = v.podd;
    tx_valid   = 1'b1;
    @(posedge clk);
    #1;
    tx_valid   = keep;
  endtask

  task automatic samples(input vec_t v, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("frame", obs(), {exp_tx(v, k), 4'b1100});
    end
  endtask

  task automatic full_frame(input vec_t v);
    samples(v, frame_len(v));
    @(posedge clk);
    #1;
    chk("frame_end", obs(), 5'b10011);
  endtask

  task automatic idle_after();
    @(posedge clk);
    #1;
    chk("done_drop", obs(), 5'b10001);
  endtask

  vec_t tbl[5];
  vec_t va, vb, vr, v0, vs, vp;

  initial begin
    n_pass   = 0;
    n_total  = 0;
    div      = 4;
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    parity_odd = 1'b0;

    tbl[0] = '{8'h55, 4, 1'b0, 10'h2AA, 1'b0};
    tbl[1] = '{8'h00, 1, 1'b1, 10'h200, 1'b1};
    tbl[2] = '{8'hFF, 3, 1'b0, 10'h3FE, 1'b0};
    tbl[3] = '{8'hA5, 2, 1'b0, 10'h34A, 1'b0};
    tbl[4] = '{8'h3C, 2, 1'b1, 10'h278, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset", obs(), 5'b10001);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle", obs(), 5'b10001);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i], 1'b0);
      full_frame(tbl[i]);
      idle_after();
    end

    // Back-to-back: upstream swaps data right after handshake, keeps valid high.
    va = tbl[3];
    vb = '{8'h3C, 2, 1'b0, 10'h278, 1'b0};
    send(va, 1'b1);
    tx_data = 8'h3C;
    full_frame(va);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    full_frame(vb);
    idle_after();

`ifdef UART_TX_PARITY_EN
    vp = '{8'hA5, 2, 1'b0, 10'h34A, 1'b0};
    send(vp, 1'b0);
    full_frame(vp);
    idle_after();
    vp = '{8'hA5, 2, 1'b1, 10'h34A, 1'b1};
    send(vp, 1'b0);
    full_frame(vp);
    idle_after();
`endif

    // Reset during data bit 3 of 0xFF, then 0x0F goes out cleanly.
    vr = '{8'hFF, 3, 1'b0, 10'h3FE, 1'b0};
    send(vr, 1'b0);
    samples(vr, 15);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid", obs(), 5'b10001);
    rst = 1'b0;
    v0 = '{8'h0F, 3, 1'b0, 10'h21E, 1'b0};
    send(v0, 1'b0);
    full_frame(v0);
    idle_after();

    // Divider stops mid-frame: line and state freeze until reset.
    vs = '{8'h55, 3, 1'b0, 10'h2AA, 1'b0};
    send(vs, 1'b0);
    samples(vs, 9);
    div = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("stall", obs(), {exp_tx(vs, 8), 4'b1100});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_rst", obs(), 5'b10001);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_idle", obs(), 5'b10001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
